// File: rtl/cfg_init_sequencer_if.sv
// Config register port between cfg_init_sequencer (master) and the filter
// config register block (slave).
interface cfg_init_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  // No valid/ready pair: cfg_we is a single-cycle write strobe that the slave
  // must accept unconditionally, and cfg_rdata is combinational from cfg_raddr.
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_waddr;
  logic [DATA_W-1:0] cfg_wdata;
  logic [ADDR_W-1:0] cfg_raddr;
  logic [DATA_W-1:0] cfg_rdata;

  modport master (
    output cfg_we, cfg_waddr, cfg_wdata, cfg_raddr,
    input  cfg_rdata
  );

  modport slave (
    input  cfg_we, cfg_waddr, cfg_wdata, cfg_raddr,
    output cfg_rdata
  );
endinterface

// File: rtl/cfg_init_sequencer.sv
// Replays a table of (addr, data, mask) entries as config writes, then reads
// them back and checks under the mask when CFG_SEQ_VERIFY_EN is defined.
module cfg_init_sequencer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tbl_we_i,
  input  logic [IDX_W-1:0]  tbl_idx_i,
  input  logic [ADDR_W-1:0] tbl_addr_i,
  input  logic [DATA_W-1:0] tbl_data_i,
  input  logic [DATA_W-1:0] tbl_mask_i,
  input  logic [IDX_W:0]    tbl_count_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [IDX_W-1:0]  err_idx_o,
  output logic [DATA_W-1:0] err_rdata_o,
  output logic [1:0]        dbg_state_o,
  cfg_init_sequencer_if.master cfg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam logic [IDX_W:0]   DEPTH_L = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_e            state_q;
  logic [IDX_W:0]    n_q;
  logic [IDX_W-1:0]  idx_q;
  logic              busy_q;
  logic              done_q;
  logic              cfg_we_q;
  logic [ADDR_W-1:0] cfg_waddr_q;
  logic [DATA_W-1:0] cfg_wdata_q;
  logic [ADDR_W-1:0] cfg_raddr_q;

  logic [ADDR_W-1:0] tbl_addr_q [DEPTH];
  logic [DATA_W-1:0] tbl_data_q [DEPTH];

  logic [IDX_W:0]    n_d;
  logic              last_idx;

  assign n_d      = (tbl_count_i > DEPTH_L) ? DEPTH_L : tbl_count_i;
  assign last_idx = ({1'b0, idx_q} == (n_q - CNT_ONE));

`ifdef CFG_SEQ_VERIFY_EN
  logic [DATA_W-1:0] tbl_mask_q [DEPTH];
  logic              error_q;
  logic [IDX_W-1:0]  err_idx_q;
  logic [DATA_W-1:0] err_rdata_q;
  logic              mismatch;

  assign mismatch = |((cfg.cfg_rdata ^ tbl_data_q[idx_q]) & tbl_mask_q[idx_q]);
`endif

  // Table is frozen whenever a sequence is running; contents are not reset.
  always_ff @(posedge clk) begin
    if (tbl_we_i && (state_q == IDLE)) begin
      tbl_addr_q[tbl_idx_i] <= tbl_addr_i;
      tbl_data_q[tbl_idx_i] <= tbl_data_i;
`ifdef CFG_SEQ_VERIFY_EN
      tbl_mask_q[tbl_idx_i] <= tbl_mask_i;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_we_q    <= 1'b0;
      cfg_waddr_q <= '0;
      cfg_wdata_q <= '0;
      cfg_raddr_q <= '0;
`ifdef CFG_SEQ_VERIFY_EN
      error_q     <= 1'b0;
      err_idx_q   <= '0;
      err_rdata_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            n_q    <= n_d;
            idx_q  <= '0;
            busy_q <= 1'b1;
`ifdef CFG_SEQ_VERIFY_EN
            error_q     <= 1'b0;
            err_idx_q   <= '0;
            err_rdata_q <= '0;
`endif
            if (n_d == '0) begin
              state_q <= FINISH;
            end else begin
              // First write is presented in the cycle right after start.
              state_q     <= WRITE;
              cfg_we_q    <= 1'b1;
              cfg_waddr_q <= tbl_addr_q[0];
              cfg_wdata_q <= tbl_data_q[0];
            end
          end
        end
        WRITE: begin
          if (last_idx) begin
            cfg_we_q <= 1'b0;
            idx_q    <= '0;
`ifdef CFG_SEQ_VERIFY_EN
            cfg_raddr_q <= tbl_addr_q[0];
            state_q     <= VERIFY;
`else
            state_q     <= FINISH;
`endif
          end else begin
            idx_q       <= idx_q + IDX_ONE;
            cfg_waddr_q <= tbl_addr_q[idx_q + IDX_ONE];
            cfg_wdata_q <= tbl_data_q[idx_q + IDX_ONE];
          end
        end
        VERIFY: begin
`ifdef CFG_SEQ_VERIFY_EN
          if (mismatch) begin
            error_q     <= 1'b1;
            err_idx_q   <= idx_q;
            err_rdata_q <= cfg.cfg_rdata;
            state_q     <= FINISH;
          end else if (last_idx) begin
            state_q <= FINISH;
          end else begin
            idx_q       <= idx_q + IDX_ONE;
            cfg_raddr_q <= tbl_addr_q[idx_q + IDX_ONE];
          end
`else
          state_q <= IDLE;
`endif
        end
        FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign dbg_state_o   = state_q;
  assign cfg.cfg_we    = cfg_we_q;
  assign cfg.cfg_waddr = cfg_waddr_q;
  assign cfg.cfg_wdata = cfg_wdata_q;
  assign cfg.cfg_raddr = cfg_raddr_q;

`ifdef CFG_SEQ_VERIFY_EN
  assign error_o     = error_q;
  assign err_idx_o   = err_idx_q;
  assign err_rdata_o = err_rdata_q;
`else
  logic unused_verify_inputs;
  assign unused_verify_inputs = ^{tbl_mask_i, cfg.cfg_rdata};
  assign error_o     = 1'b0;
  assign err_idx_o   = '0;
  assign err_rdata_o = '0;
`endif

endmodule

// File: tb/tb_cfg_init_sequencer.sv
// Directed bench for cfg_init_sequencer: table-driven sequences against a
// small config register target, plus depth clamp and mid-sequence reset.
module tb_cfg_init_sequencer;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int BUDGET = 100;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              tbl_we = 1'b0;
  logic [IDX_W-1:0]  tbl_idx = '0;
  logic [ADDR_W-1:0] tbl_addr = '0;
  logic [DATA_W-1:0] tbl_data = '0;
  logic [DATA_W-1:0] tbl_mask = '0;
  logic [IDX_W:0]    tbl_count = '0;
  logic              start = 1'b0;
  logic              busy, done, error;
  logic [IDX_W-1:0]  err_idx;
  logic [DATA_W-1:0] err_rdata;
  logic [1:0]        dbg_state;

  cfg_init_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cfg_bus ();

  cfg_init_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tbl_we_i    (tbl_we),
    .tbl_idx_i   (tbl_idx),
    .tbl_addr_i  (tbl_addr),
    .tbl_data_i  (tbl_data),
    .tbl_mask_i  (tbl_mask),
    .tbl_count_i (tbl_count),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .err_idx_o   (err_idx),
    .err_rdata_o (err_rdata),
    .dbg_state_o (dbg_state),
    .cfg         (cfg_bus.slave)
  );

  // Target register block: addresses 1 and 6 are 16-bit registers.
  logic [DATA_W-1:0] tgt_q [16];
  function automatic logic [DATA_W-1:0] tgt_width(input logic [ADDR_W-1:0] a);
    return (a == 4'd1 || a == 4'd6) ? 32'h0000FFFF : 32'hFFFFFFFF;
  endfunction
  always @(posedge clk)
    if (cfg_bus.cfg_we) tgt_q[cfg_bus.cfg_waddr] <= cfg_bus.cfg_wdata & tgt_width(cfg_bus.cfg_waddr);
  assign cfg_bus.cfg_rdata = tgt_q[cfg_bus.cfg_raddr];

  // scoreboard
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int wr_seen;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sample_write();
    logic [ADDR_W+DATA_W-1:0] e;
    if (cfg_bus.cfg_we) begin
      wr_seen++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr", {28'd0, cfg_bus.cfg_waddr}, {28'd0, e[ADDR_W+DATA_W-1:DATA_W]});
        check("write_data", cfg_bus.cfg_wdata, e[DATA_W-1:0]);
      end
    end
  endtask

  // driver tasks
  task automatic load_entry(input int idx, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
    @(negedge clk);
    tbl_we = 1'b1; tbl_idx = IDX_W'(idx); tbl_addr = a; tbl_data = d; tbl_mask = m;
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic run_seq(input logic [IDX_W:0] count, input int inject_cyc, output int done_cyc);
    done_cyc = -1;
    wr_seen  = 0;
    @(negedge clk);
    tbl_count = count;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    sample_write();
    for (int c = 1; c <= BUDGET; c++) begin
      if (inject_cyc > 0 && c == inject_cyc) begin
        @(negedge clk);
        start = 1'b1; tbl_we = 1'b1; tbl_idx = '0; tbl_addr = 4'd9; tbl_data = '0; tbl_mask = '0;
      end
      if (inject_cyc > 0 && c == inject_cyc + 1) begin
        @(negedge clk);
        start = 1'b0; tbl_we = 1'b0;
      end
      @(posedge clk); #1;
      sample_write();
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    string             name;
    bit                load;
    int                n_ent;
    logic [ADDR_W-1:0] addr [4];
    logic [DATA_W-1:0] data [4];
    logic [DATA_W-1:0] mask [4];
    logic [IDX_W:0]    count;
    int                inject;
    int                done_v;
    int                done_nv;
    logic              err;
    logic [IDX_W-1:0]  err_idx;
    logic [DATA_W-1:0] err_rdata;
  } vec_t;

  function automatic vec_t add_ent(input vec_t v, input logic [ADDR_W-1:0] a,
                                   input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
    vec_t r = v;
    r.addr[r.n_ent] = a;
    r.data[r.n_ent] = d;
    r.mask[r.n_ent] = m;
    r.n_ent++;
    return r;
  endfunction

  function automatic vec_t mk(input string name, input bit load, input logic [IDX_W:0] count,
                              input int inject, input int done_v, input int done_nv, input logic err,
                              input logic [IDX_W-1:0] eidx, input logic [DATA_W-1:0] erd);
    vec_t r;
    r.name = name; r.load = load; r.n_ent = 0; r.count = count; r.inject = inject;
    r.done_v = done_v; r.done_nv = done_nv; r.err = err; r.err_idx = eidx; r.err_rdata = erd;
    for (int k = 0; k < 4; k++) begin
      r.addr[k] = '0; r.data[k] = '0; r.mask[k] = '0;
    end
    return r;
  endfunction

  function automatic vec_t plan3(input vec_t v);
    vec_t r = v;
    r = add_ent(r, 4'd4, 32'h0A000200, 32'hFFFFFFFF);
    r = add_ent(r, 4'd5, 32'hFFFFFF00, 32'hFFFFFFFF);
    r = add_ent(r, 4'd6, 32'h000063DD, 32'h0000FFFF);
    return r;
  endfunction

  task automatic run_vector(input vec_t v);
    int done_cyc;
    int exp_done;
    logic              exp_err;
    logic [IDX_W-1:0]  exp_eidx;
    logic [DATA_W-1:0] exp_erd;
    logic [ADDR_W-1:0] exp_raddr;
`ifdef CFG_SEQ_VERIFY_EN
    exp_done = v.done_v; exp_err = v.err; exp_eidx = v.err_idx; exp_erd = v.err_rdata;
    exp_raddr = v.err ? v.addr[v.err_idx] : v.addr[(v.count == 0) ? 0 : int'(v.count) - 1];
`else
    exp_done = v.done_nv; exp_err = 1'b0; exp_eidx = '0; exp_erd = '0;
    exp_raddr = '0;
`endif
    if (v.load)
      for (int k = 0; k < v.n_ent; k++) load_entry(k, v.addr[k], v.data[k], v.mask[k]);
    exp_q.delete();
    for (int k = 0; k < int'(v.count); k++) exp_q.push_back({v.addr[k], v.data[k]});
    run_seq(v.count, v.inject, done_cyc);
    check({v.name, "_done_cycle"}, done_cyc, exp_done);
    check({v.name, "_writes"}, wr_seen, v.count);
    check({v.name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({v.name, "_error"}, {31'd0, error}, {31'd0, exp_err});
    check({v.name, "_err_idx"}, {28'd0, err_idx}, {28'd0, exp_eidx});
    check({v.name, "_err_rdata"}, err_rdata, exp_erd);
    if (v.count != 0) check({v.name, "_raddr"}, {28'd0, cfg_bus.cfg_raddr}, {28'd0, exp_raddr});
    @(posedge clk); #1;
    check({v.name, "_done_width"}, {31'd0, done}, 32'd0);
    check({v.name, "_error_hold"}, {31'd0, error}, {31'd0, exp_err});
  endtask

  vec_t vecs [9];

  initial begin
    int done_cyc;
    vecs[0] = plan3(mk("plan3", 1'b1, 5'd3, 0, 7, 4, 1'b0, 4'd0, 32'h0));
    vecs[1] = add_ent(mk("mis_full", 1'b1, 5'd1, 0, 3, 2, 1'b1, 4'd0, 32'h0000ABCD),
                      4'd1, 32'h1234ABCD, 32'hFFFFFFFF);
    vecs[2] = add_ent(mk("mis_masked", 1'b1, 5'd1, 0, 3, 2, 1'b0, 4'd0, 32'h0),
                      4'd1, 32'h1234ABCD, 32'h0000FFFF);
    vecs[3] = mk("count0", 1'b0, 5'd0, 0, 1, 1, 1'b0, 4'd0, 32'h0);
    vecs[4] = mk("dup_addr", 1'b1, 5'd3, 0, 5, 4, 1'b1, 4'd0, 32'h12345678);
    vecs[4] = add_ent(vecs[4], 4'd2, 32'hAAAA5555, 32'hFFFFFFFF);
    vecs[4] = add_ent(vecs[4], 4'd2, 32'h12345678, 32'hFFFFFFFF);
    vecs[4] = add_ent(vecs[4], 4'd3, 32'hDEADBEEF, 32'hFFFFFFFF);
    vecs[5] = mk("mis_idx1", 1'b1, 5'd3, 0, 6, 4, 1'b1, 4'd1, 32'h0000F00D);
    vecs[5] = add_ent(vecs[5], 4'd0, 32'h11111111, 32'hFFFFFFFF);
    vecs[5] = add_ent(vecs[5], 4'd1, 32'hCAFEF00D, 32'hFFFFFFFF);
    vecs[5] = add_ent(vecs[5], 4'd7, 32'h00000001, 32'hFFFFFFFF);
    vecs[6] = plan3(mk("busy_pulse", 1'b1, 5'd3, 2, 7, 4, 1'b0, 4'd0, 32'h0));
    vecs[7] = plan3(mk("table_kept", 1'b0, 5'd3, 0, 7, 4, 1'b0, 4'd0, 32'h0));
    vecs[8] = plan3(mk("count2", 1'b0, 5'd2, 0, 5, 3, 1'b0, 4'd0, 32'h0));

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_err_idx", {28'd0, err_idx}, 32'd0);
    check("rst_err_rdata", err_rdata, 32'd0);
    check("rst_cfg_we", {31'd0, cfg_bus.cfg_we}, 32'd0);
    check("rst_cfg_waddr", {28'd0, cfg_bus.cfg_waddr}, 32'd0);
    check("rst_cfg_wdata", cfg_bus.cfg_wdata, 32'd0);
    check("rst_cfg_raddr", {28'd0, cfg_bus.cfg_raddr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_vector(vecs[i]);
      if (i == 0) begin
        check("tgt_ip_base", tgt_q[4], 32'h0A000200);
        check("tgt_udp_dst_port", tgt_q[6], 32'd25565);
      end
    end

    // depth clamp: count 20 on a 16-entry table
    for (int k = 0; k < DEPTH; k++) load_entry(k, ADDR_W'(k), 32'h5A000000 | k, 32'h0000FFFF);
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) exp_q.push_back({ADDR_W'(k), 32'h5A000000 | k});
    run_seq(5'd20, 0, done_cyc);
    check("clamp_writes", wr_seen, 16);
`ifdef CFG_SEQ_VERIFY_EN
    check("clamp_done_cycle", done_cyc, 33);
`else
    check("clamp_done_cycle", done_cyc, 17);
`endif
    check("clamp_error", {31'd0, error}, 32'd0);

    // reset during the second write cycle
    for (int k = 0; k < 3; k++) load_entry(k, vecs[0].addr[k], vecs[0].data[k], vecs[0].mask[k]);
    @(negedge clk);
    tbl_count = 5'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_second_write_we", {31'd0, cfg_bus.cfg_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cfg_we", {31'd0, cfg_bus.cfg_we}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_waddr", {28'd0, cfg_bus.cfg_waddr}, 32'd0);
    check("mid_rst_wdata", cfg_bus.cfg_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("mid_rst_no_done", {31'd0, done}, 32'd0);
    end
    run_vector(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
